// File: rtl/state_machine.sv
// BIST sequencing controller: on a rising edge of bist_start, steps through
// timed INIT, RUN and FINISH phases, pulses bist_end for one cycle, then
// returns to idle. All outputs are registered Moore flags.
module state_machine #(
  parameter int unsigned INIT_CYCLES   = 4,
  parameter int unsigned RUN_CYCLES    = 16,
  parameter int unsigned FINISH_CYCLES = 2,
  parameter int unsigned CNT_W         = 8
) (
  input  logic clock,
  input  logic reset,
  input  logic bist_start,
  output logic mode,
  output logic init,
  output logic running,
  output logic finish,
  output logic bist_end
);

  typedef enum logic [2:0] {
    StIdle,
    StInit,
    StRun,
    StFinish,
    StDone
  } state_e;

  // Terminal counts; each phase leaves when the counter reaches CYCLES-1.
  localparam logic [CNT_W-1:0] InitLast   = CNT_W'(INIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] RunLast    = CNT_W'(RUN_CYCLES - 1);
  localparam logic [CNT_W-1:0] FinishLast = CNT_W'(FINISH_CYCLES - 1);
  localparam logic [CNT_W-1:0] CntOne     = CNT_W'(1);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             start_q;
  logic             start_evt;

  // A start is a 0->1 transition of bist_start; start_q tracks it every cycle.
  assign start_evt = bist_start & ~start_q;

  // Sequencer: state, phase counter, start history and the flags that
  // correspond to the next state, all updated together.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      start_q  <= 1'b0;
      mode     <= 1'b0;
      init     <= 1'b0;
      running  <= 1'b0;
      finish   <= 1'b0;
      bist_end <= 1'b0;
    end else begin
      start_q <= bist_start;
      unique case (state_q)
        StIdle: begin
          if (start_evt) begin
            state_q <= StInit;
            cnt_q   <= '0;
            mode    <= 1'b1;
            init    <= 1'b1;
          end
        end
        StInit: begin
          if (cnt_q == InitLast) begin
            state_q <= StRun;
            cnt_q   <= '0;
            init    <= 1'b0;
            running <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CntOne;
          end
        end
        StRun: begin
          if (cnt_q == RunLast) begin
            state_q <= StFinish;
            cnt_q   <= '0;
            running <= 1'b0;
            finish  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CntOne;
          end
        end
        StFinish: begin
          if (cnt_q == FinishLast) begin
            state_q  <= StDone;
            cnt_q    <= '0;
            finish   <= 1'b0;
            bist_end <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CntOne;
          end
        end
        StDone: begin
          // Starts coinciding with this edge are deliberately dropped.
          state_q  <= StIdle;
          mode     <= 1'b0;
          bist_end <= 1'b0;
        end
        default: begin
          state_q  <= StIdle;
          cnt_q    <= '0;
          mode     <= 1'b0;
          init     <= 1'b0;
          running  <= 1'b0;
          finish   <= 1'b0;
          bist_end <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_state_machine.sv
// Directed bench for state_machine: default-parameter instance plus a
// 1/1/1 override instance sharing clock and reset.
module tb_state_machine;

  logic clock;
  logic reset;
  logic start_a, start_b;
  logic mode_a, init_a, running_a, finish_a, end_a;
  logic mode_b, init_b, running_b, finish_b, end_b;
  logic [4:0] obs_a, obs_b;

  int checks;
  int errors;

  state_machine u_dut_a (
    .clock     (clock),
    .reset     (reset),
    .bist_start(start_a),
    .mode      (mode_a),
    .init      (init_a),
    .running   (running_a),
    .finish    (finish_a),
    .bist_end  (end_a)
  );

  state_machine #(
    .INIT_CYCLES  (1),
    .RUN_CYCLES   (1),
    .FINISH_CYCLES(1),
    .CNT_W        (8)
  ) u_dut_b (
    .clock     (clock),
    .reset     (reset),
    .bist_start(start_b),
    .mode      (mode_b),
    .init      (init_b),
    .running   (running_b),
    .finish    (finish_b),
    .bist_end  (end_b)
  );

  assign obs_a = {mode_a, init_a, running_a, finish_a, end_a};
  assign obs_b = {mode_b, init_b, running_b, finish_b, end_b};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (mode,init,run,fin,end)", tag, obs, exp);
    end
  endtask

  // Expected flags n cycles after the start edge (edge 1 = start edge).
  function automatic logic [4:0] exp_flags(input int n, input int ic, input int rc,
                                           input int fc);
    if (n >= 1 && n <= ic)                       return 5'b11000;
    if (n > ic && n <= ic + rc)                  return 5'b10100;
    if (n > ic + rc && n <= ic + rc + fc)        return 5'b10010;
    if (n == ic + rc + fc + 1)                   return 5'b10001;
    return 5'b00000;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Drop start_a for one sampled edge, then raise it; next edge is the start edge.
  task automatic retrigger_a();
    @(negedge clock);
    start_a = 1'b0;
    @(negedge clock);
    start_a = 1'b1;
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    reset   = 1'b0;
    start_a = 1'b0;
    start_b = 1'b0;

    // Reset hold with toggling start: all outputs stay low.
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      start_a = ~start_a;
      start_b = ~start_b;
      tick();
      check_eq($sformatf("rst_hold_a%0d", i), obs_a, 5'b00000);
      check_eq($sformatf("rst_hold_b%0d", i), obs_b, 5'b00000);
    end

    // Release with start low: remain idle.
    @(negedge clock);
    start_a = 1'b0;
    start_b = 1'b0;
    reset   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq($sformatf("idle_a%0d", i), obs_a, 5'b00000);
    end

    // Nominal run, start held high afterwards: exactly one sequence.
    @(negedge clock);
    start_a = 1'b1;
    for (int n = 1; n <= 30; n++) begin
      tick();
      check_eq($sformatf("nom_c%0d", n), obs_a, exp_flags(n, 4, 16, 2));
    end

    // Re-trigger gives an identical second sequence.
    retrigger_a();
    for (int n = 1; n <= 26; n++) begin
      tick();
      check_eq($sformatf("retrig_c%0d", n), obs_a, exp_flags(n, 4, 16, 2));
    end

    // Toggle start during RUN: timing unchanged, no extra sequence.
    retrigger_a();
    for (int n = 1; n <= 30; n++) begin
      tick();
      check_eq($sformatf("midrun_c%0d", n), obs_a, exp_flags(n, 4, 16, 2));
      if (n >= 6 && n <= 14) start_a = n[0];
      if (n == 15) start_a = 1'b0;
    end

    // Async abort mid-RUN: immediate clear, no bist_end.
    retrigger_a();
    for (int n = 1; n <= 10; n++) begin
      tick();
      check_eq($sformatf("abort_pre_c%0d", n), obs_a, exp_flags(n, 4, 16, 2));
    end
    #2;
    reset = 1'b0;
    #1;
    check_eq("abort_immediate", obs_a, 5'b00000);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq($sformatf("abort_hold%0d", i), obs_a, 5'b00000);
    end
    // Release with start still high: starts on the first edge.
    @(negedge clock);
    reset = 1'b1;
    for (int n = 1; n <= 25; n++) begin
      tick();
      check_eq($sformatf("post_abort_c%0d", n), obs_a, exp_flags(n, 4, 16, 2));
    end

    // Minimum phase lengths on the override instance.
    @(negedge clock);
    start_b = 1'b1;
    for (int n = 1; n <= 7; n++) begin
      tick();
      check_eq($sformatf("min_c%0d", n), obs_b, exp_flags(n, 1, 1, 1));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
